control_pajarito: RTL and testbench
===================================

CONTROL_PAJARITO -- requirements
Module: control_pajarito

Interface
REQ-001 SHALL have parameter TICK_DIV, default 833333, clk cycles per movement tick (minimum 2).
REQ-002 SHALL have parameter SUBIDA_TICKS, default 3, number of ticks the bird rises per jump (minimum 1).
REQ-003 SHALL have parameter Y_MIN, default 15, top limit in pixels; posy at or below it ends the game.
REQ-004 SHALL have parameter Y_MAX, default 460, bottom limit in pixels; posy at or above it ends the game.
REQ-005 SHALL have port clk, input, 1, single system clock; all state on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port btn_salto, input, 1, jump button, already synchronous and debounced.
REQ-008 SHALL have port btn_pausa, input, 1, pause button, already synchronous and debounced.
REQ-009 SHALL have port colision, input, 1, level high while the bird overlaps a pipe.
REQ-010 SHALL have port posy, input, 10, current bird Y position from the movement block.
REQ-011 SHALL have port en_time_out, output, 1, one-cycle movement tick pulse.
REQ-012 SHALL have port en_subiendo, output, 1, high while the bird must rise.
REQ-013 SHALL have port pausa, output, 1, high whenever the bird must hold position.
REQ-014 SHALL have port estado, output, 2, current game state encoding.
REQ-015 SHALL have port game_over, output, 1, high in state FIN.

Function
REQ-016 SHALL implement the prescaler as a free-running counter 0..TICK_DIV-1, with en_time_out high for exactly the one cycle in which count = TICK_DIV-1, in every state.
REQ-017 SHALL have the FSM states INICIO=0, JUGANDO=1, PAUSADO=2 and FIN=3, with all outputs registered.
REQ-018 SHALL detect button edges against a one-cycle-delayed copy of each button, so a press is one cycle with the button high and the previous sample low.
REQ-019 SHALL move INICIO -> JUGANDO on a btn_salto edge and count that edge as the first jump.
REQ-020 SHALL move JUGANDO -> PAUSADO on a btn_pausa edge, and PAUSADO -> JUGANDO on the next btn_pausa edge.
REQ-021 SHALL move JUGANDO -> FIN when colision=1, posy <= Y_MIN or posy >= Y_MAX; FIN is left only by reset.
REQ-022 SHALL drive pausa = 1 in INICIO, PAUSADO and FIN, and pausa = 0 in JUGANDO.
REQ-023 SHALL load the jump counter with SUBIDA_TICKS on a jump edge in JUGANDO (or on the INICIO exit).
REQ-024 SHALL decrement the jump counter on each en_time_out while in JUGANDO, and drive en_subiendo = (counter != 0).
REQ-025 SHALL reload the jump counter to SUBIDA_TICKS on a jump edge while it is still nonzero (no accumulation).
REQ-026 SHALL, when a jump edge and a tick occur in the same cycle, reload the counter to SUBIDA_TICKS with no decrement.
REQ-027 SHALL, when pause and jump edges occur in the same cycle in JUGANDO, take the pause and ignore the jump.
REQ-028 SHALL, when an end condition and a pause edge occur in the same cycle, go to FIN.
REQ-029 SHALL freeze the jump counter in PAUSADO, ignore jump edges there, and clear the counter on entry to FIN.
REQ-030 SHALL ignore btn_pausa in INICIO and FIN.
REQ-031 SHALL assert en_subiendo the cycle after the jump edge cycle (one-cycle latency).
REQ-032 SHALL assert game_over in the cycle after the end condition is sampled.

Reset
REQ-033 SHALL, while rst = 0, asynchronously force prescaler 0, jump counter 0, button history 0, state INICIO, en_time_out 0, en_subiendo 0, pausa 1, estado 0 and game_over 0.
REQ-034 SHALL, on reset asserted mid-game, abandon the game immediately with no pending tick or jump surviving.

Configuration
REQ-035 SHALL enable pause when macro CTRL_PAUSA_EN is defined, with the behaviour of REQ-020 and REQ-027.
REQ-036 SHALL, when CTRL_PAUSA_EN is undefined, keep the btn_pausa port but ignore it and make PAUSADO unreachable; all other behaviour is unchanged.

Structure
REQ-037 SHALL place the state encoding constants and the default parameter values in shared package pajarito_pkg.
REQ-038 SHALL implement the prescaler as sub-module generador_tick (parameter TICK_DIV; ports clk, rst, tick), with counter width clog2(TICK_DIV).

Verification
REQ-039 SHALL check reset: TICK_DIV=4, release rst -> en_time_out pulses on cycles 4, 8, 12; estado=0 and pausa=1 throughout.
REQ-040 SHALL check jump: TICK_DIV=4, SUBIDA_TICKS=3, btn_salto edge in INICIO -> estado=1 and en_subiendo=1 next cycle, then en_subiendo low after the 3rd tick.
REQ-041 SHALL check re-jump: second btn_salto edge while the counter = 1, coinciding with a tick -> counter = 3, en_subiendo stays high for 3 more ticks.
REQ-042 SHALL check pause: btn_pausa edge in JUGANDO with the counter = 2 -> pausa=1 and estado=2, ticks continue but the counter stays 2; second edge -> estado=1.
REQ-043 SHALL check end conditions: posy=460, or colision=1 together with a btn_pausa edge -> estado=3 and game_over=1 next cycle; later btn_salto/btn_pausa edges -> no change until rst.
REQ-044 SHALL check the build without CTRL_PAUSA_EN: btn_pausa edges in JUGANDO -> estado stays 1 and pausa stays 0.

Source files
------------

// File: rtl/pajarito_pkg.sv
// Shared game-state encoding, bus widths and default parameters for the bird controller.
package pajarito_pkg;

  localparam int unsigned ESTADO_W = 2;
  localparam int unsigned POSY_W   = 10;

  localparam int unsigned DEF_TICK_DIV     = 833333;
  localparam int unsigned DEF_SUBIDA_TICKS = 3;
  localparam int unsigned DEF_Y_MIN        = 15;
  localparam int unsigned DEF_Y_MAX        = 460;

  typedef enum logic [ESTADO_W-1:0] {
    INICIO  = 2'd0,
    JUGANDO = 2'd1,
    PAUSADO = 2'd2,
    FIN     = 2'd3
  } estado_e;

endpackage

// File: rtl/generador_tick.sv
// Free-running prescaler 0..TICK_DIV-1; tick is a registered one-cycle pulse while count is TICK_DIV-1.
module generador_tick
  import pajarito_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // The pulse flop mirrors the compare on the next count, so it is high in the same cycle as count = last.
  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/control_pajarito.sv
// Flappy-bird game controller: movement tick, jump timing and game FSM.
// Pause support is compiled in only when CTRL_PAUSA_EN is defined.
module control_pajarito
  import pajarito_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned SUBIDA_TICKS = DEF_SUBIDA_TICKS,
  parameter int unsigned Y_MIN        = DEF_Y_MIN,
  parameter int unsigned Y_MAX        = DEF_Y_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_salto,
  input  logic                btn_pausa,
  input  logic                colision,
  input  logic [POSY_W-1:0]   posy,
  output logic                en_time_out,
  output logic                en_subiendo,
  output logic                pausa,
  output logic [ESTADO_W-1:0] estado,
  output logic                game_over
);

  localparam int unsigned CNT_W = $clog2(SUBIDA_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_CARGA = CNT_W'(SUBIDA_TICKS);

`ifdef CTRL_PAUSA_EN
  localparam bit PAUSA_EN = 1'b1;
`else
  localparam bit PAUSA_EN = 1'b0;
`endif

  logic             tick;
  estado_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             salto_prev_q, pausa_prev_q;
  logic             en_subiendo_q, en_subiendo_d;
  logic             pausa_q, pausa_d;
  logic             game_over_q, game_over_d;
  logic             salto_edge_c, pausa_edge_c, fin_c;

  generador_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_generador_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Press detection against last cycle's sample; pause edges vanish when the feature is compiled out.
  always_comb begin
    salto_edge_c = btn_salto & ~salto_prev_q;
    pausa_edge_c = PAUSA_EN & btn_pausa & ~pausa_prev_q;
    fin_c        = colision
                 | (posy <= POSY_W'(Y_MIN))
                 | (posy >= POSY_W'(Y_MAX));
  end

  // Priority in JUGANDO: end condition, then pause, then jump reload, then tick decrement.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INICIO: begin
        if (salto_edge_c) begin
          state_d = JUGANDO;
          cnt_d   = CNT_CARGA;
        end
      end
      JUGANDO: begin
        if (fin_c) begin
          state_d = FIN;
          cnt_d   = '0;
        end else if (pausa_edge_c) begin
          state_d = PAUSADO;
        end else if (salto_edge_c) begin
          cnt_d = CNT_CARGA;
        end else if (tick && (cnt_q != '0)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PAUSADO: begin
        if (pausa_edge_c) begin
          state_d = JUGANDO;
        end
      end
      FIN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = INICIO;
        cnt_d   = '0;
      end
    endcase
    en_subiendo_d = (cnt_d != '0);
    pausa_d       = (state_d != JUGANDO);
    game_over_d   = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= INICIO;
      cnt_q         <= '0;
      salto_prev_q  <= 1'b0;
      pausa_prev_q  <= 1'b0;
      en_subiendo_q <= 1'b0;
      pausa_q       <= 1'b1;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      salto_prev_q  <= btn_salto;
      pausa_prev_q  <= btn_pausa;
      en_subiendo_q <= en_subiendo_d;
      pausa_q       <= pausa_d;
      game_over_q   <= game_over_d;
    end
  end

  assign en_time_out = tick;
  assign en_subiendo = en_subiendo_q;
  assign pausa       = pausa_q;
  assign estado      = state_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_control_pajarito.sv
// Directed bench for control_pajarito (TICK_DIV=4, SUBIDA_TICKS=3); pause checks follow CTRL_PAUSA_EN.
module tb_control_pajarito;
  import pajarito_pkg::*;

  logic              clk;
  logic              rst;
  logic              btn_salto;
  logic              btn_pausa;
  logic              colision;
  logic [POSY_W-1:0] posy;
  logic              en_time_out;
  logic              en_subiendo;
  logic              pausa;
  logic [1:0]        estado;
  logic              game_over;

  int n;
  int errs;
  int checks;

  control_pajarito #(
    .TICK_DIV    (4),
    .SUBIDA_TICKS(3),
    .Y_MIN       (15),
    .Y_MAX       (460)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_salto  (btn_salto),
    .btn_pausa  (btn_pausa),
    .colision   (colision),
    .posy       (posy),
    .en_time_out(en_time_out),
    .en_subiendo(en_subiendo),
    .pausa      (pausa),
    .estado     (estado),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n);
    end
  endtask

  // One rising edge, then settle 1 time unit; n counts edges since reset release.
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic press_salto(input int e);
    run_to(e - 1);
    btn_salto = 1'b1;
    step();
    btn_salto = 1'b0;
  endtask

  task automatic press_pausa(input int e);
    run_to(e - 1);
    btn_pausa = 1'b1;
    step();
    btn_pausa = 1'b0;
  endtask

  task automatic press_both(input int e);
    run_to(e - 1);
    btn_salto = 1'b1;
    btn_pausa = 1'b1;
    step();
    btn_salto = 1'b0;
    btn_pausa = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    btn_salto = 1'b0;
    btn_pausa = 1'b0;
    colision  = 1'b0;
    posy      = 10'd200;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_pausa", 32'(pausa), 32'd1);
    chk("rst_tick", 32'(en_time_out), 32'd0);
    chk("rst_subiendo", 32'(en_subiendo), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    rst = 1'b1;
    n   = 0;
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    n      = 0;

    // Section 1: tick cadence, jumps, re-jump on tick, pause, end by posy.
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("tick_cadence", 32'(en_time_out), 32'((n % 4) == 3));
      if ((i % 4) == 0) begin
        chk("idle_estado", 32'(estado), 32'd0);
        chk("idle_pausa", 32'(pausa), 32'd1);
      end
    end

    press_salto(13);
    chk("start_estado", 32'(estado), 32'd1);
    chk("start_subiendo", 32'(en_subiendo), 32'd1);
    chk("start_pausa", 32'(pausa), 32'd0);
    run_to(23);
    chk("rise_before_3rd", 32'(en_subiendo), 32'd1);
    run_to(24);
    chk("rise_after_3rd", 32'(en_subiendo), 32'd0);

    press_salto(26);
    chk("jump2_subiendo", 32'(en_subiendo), 32'd1);
    run_to(35);
    chk("tick_at_rejump", 32'(en_time_out), 32'd1);
    press_salto(36);
    run_to(47);
    chk("rejump_held", 32'(en_subiendo), 32'd1);
    run_to(48);
    chk("rejump_done", 32'(en_subiendo), 32'd0);

    press_salto(50);
`ifdef CTRL_PAUSA_EN
    press_pausa(54);
    chk("pause_estado", 32'(estado), 32'd2);
    chk("pause_pausa", 32'(pausa), 32'd1);
    chk("pause_subiendo", 32'(en_subiendo), 32'd1);
    press_salto(57);
    chk("pause_ignores_jump", 32'(estado), 32'd2);
    run_to(59);
    chk("pause_tick_runs", 32'(en_time_out), 32'd1);
    press_both(62);
    chk("resume_estado", 32'(estado), 32'd1);
    chk("resume_pausa", 32'(pausa), 32'd0);
    run_to(67);
    chk("resume_frozen_cnt", 32'(en_subiendo), 32'd1);
    run_to(68);
    chk("resume_cnt_done", 32'(en_subiendo), 32'd0);
`else
    press_pausa(54);
    chk("nopause_estado", 32'(estado), 32'd1);
    chk("nopause_pausa", 32'(pausa), 32'd0);
    run_to(59);
    chk("nopause_rise", 32'(en_subiendo), 32'd1);
    run_to(60);
    chk("nopause_cnt_done", 32'(en_subiendo), 32'd0);
    press_pausa(62);
    chk("nopause_estado2", 32'(estado), 32'd1);
    chk("nopause_pausa2", 32'(pausa), 32'd0);
`endif

    run_to(72);
    posy = 10'd459;
    step();
    chk("posy459_estado", 32'(estado), 32'd1);
    chk("posy459_pausa", 32'(pausa), 32'd0);
    posy = 10'd460;
    step();
    chk("posy460_estado", 32'(estado), 32'd3);
    chk("posy460_game_over", 32'(game_over), 32'd1);
    chk("posy460_pausa", 32'(pausa), 32'd1);
    press_salto(76);
    press_pausa(78);
    run_to(79);
    chk("fin_sticky_estado", 32'(estado), 32'd3);
    chk("fin_sticky_game_over", 32'(game_over), 32'd1);

    // Section 2: reset asserted mid-rise takes effect without a clock edge.
    do_reset();
    press_salto(3);
    run_to(5);
    chk("midgame_subiendo", 32'(en_subiendo), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_estado", 32'(estado), 32'd0);
    chk("async_rst_subiendo", 32'(en_subiendo), 32'd0);
    chk("async_rst_pausa", 32'(pausa), 32'd1);

    // Section 3: posy just above Y_MIN keeps playing; collision wins over a pause edge.
    do_reset();
    posy = 10'd16;
    press_salto(2);
    run_to(4);
    chk("posy16_estado", 32'(estado), 32'd1);
    colision  = 1'b1;
    btn_pausa = 1'b1;
    step();
    colision  = 1'b0;
    btn_pausa = 1'b0;
    chk("colision_estado", 32'(estado), 32'd3);
    chk("colision_game_over", 32'(game_over), 32'd1);
    chk("colision_subiendo", 32'(en_subiendo), 32'd0);

    // Section 4: posy equal to Y_MIN ends the game.
    do_reset();
    press_salto(2);
    posy = 10'd15;
    step();
    chk("posy15_estado", 32'(estado), 32'd3);
    chk("posy15_game_over", 32'(game_over), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
